// File: rtl/pp_mult_pkg.sv
// Shared types and sizing helpers for the row-serial partial-product multiplier.
// The helpers let instantiating code derive cycle counts and counter widths.
package pp_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Ceiling division, used for the fixed cycle count N = ceil(WIDTH/ROWS_PER_CYC).
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   function automatic int idx_width(input int width, input int rows);
      return $clog2(width + rows);
   endfunction

endpackage

// File: rtl/pp_and_row.sv
// One shifted partial-product row: (a & {WIDTH{b_bit}}) << shift.
// Rows at or beyond the operand width contribute nothing.
module pp_and_row #(
   parameter int WIDTH = 92,
   parameter int IW    = 7
) (
   input  logic [WIDTH-1:0]   a,
   input  logic               b_bit,
   input  logic [IW-1:0]      shift,
   output logic [2*WIDTH-1:0] row
);

   localparam logic [IW-1:0] WIDTH_I = IW'(WIDTH);

   logic [2*WIDTH-1:0] masked;

   always_comb begin
      masked = {{WIDTH{1'b0}}, a & {WIDTH{b_bit}}};
      row    = (shift >= WIDTH_I) ? '0 : (masked << shift);
   end

endmodule

// File: rtl/pp_row_accumulator.sv
// Sequential multiplier: sums ROWS_PER_CYC partial-product rows per cycle into a
// 2*WIDTH accumulator, with valid/ready handshakes on operands and product.
module pp_row_accumulator
   import pp_mult_pkg::*;
#(
   parameter int WIDTH        = 92,
   parameter int ROWS_PER_CYC = 4,
   parameter bit EARLY_EXIT   = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int            IW      = idx_width(WIDTH, ROWS_PER_CYC);
   localparam int            BE      = 2 ** IW;
   localparam logic [IW-1:0] WIDTH_I = IW'(WIDTH);
   localparam logic [IW-1:0] ROWS_I  = IW'(ROWS_PER_CYC);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod_q, prod_d, acc_sum;
   logic [IW-1:0]      idx_q, idx_d, idx_next;
   logic               run_exit;
   logic [BE-1:0]      b_ext;

   logic [2*WIDTH-1:0]      row_w   [ROWS_PER_CYC];
   logic [IW-1:0]           row_idx [ROWS_PER_CYC];
   logic [ROWS_PER_CYC-1:0] row_bit;

   // Zero-extended copy of b so every reachable row index selects a real bit.
   assign b_ext = BE'(b_q);

   generate
      for (genvar gi = 0; gi < ROWS_PER_CYC; gi++) begin : g_row
         assign row_idx[gi] = idx_q + IW'(gi);
         assign row_bit[gi] = b_ext[row_idx[gi]];

         pp_and_row #(
            .WIDTH (WIDTH),
            .IW    (IW)
         ) u_row (
            .a     (a_q),
            .b_bit (row_bit[gi]),
            .shift (row_idx[gi]),
            .row   (row_w[gi])
         );
      end
   endgenerate

   always_comb begin
      idx_next = idx_q + ROWS_I;
      acc_sum  = acc_q;
      for (int k = 0; k < ROWS_PER_CYC; k++) begin
         acc_sum = acc_sum + row_w[k];
      end
      // A shift past the top leaves zero, covering the empty-range case too.
      run_exit = (idx_next >= WIDTH_I) ||
                 (EARLY_EXIT && ((b_q >> idx_next) == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (run_exit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      product   = prod_q;
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      idx_d  = idx_q;
      prod_d = prod_q;
      if (!abort) begin
         if (state_q == IDLE && in_valid) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            idx_d = '0;
         end else if (state_q == RUN) begin
            acc_d = acc_sum;
            idx_d = idx_next;
            // Product register only changes on completion, so it holds across backpressure.
            if (run_exit) prod_d = acc_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         idx_q  <= '0;
         prod_q <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         idx_q  <= idx_d;
         prod_q <= prod_d;
      end
   end

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Bench for pp_row_accumulator: three instances (fixed-latency, early-exit, 8-bit)
// checked against a plain-arithmetic product and latency model.
module tb_pp_row_accumulator;
   import pp_mult_pkg::*;

   localparam int W  = 92;
   localparam int PW = 184;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    iv, ordy, abt;
   logic [2:0]    irdy, ov, bsy;
   logic [W-1:0]  a_s, b_s;
   logic [PW-1:0] p0, p1;
   logic [15:0]   p2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Instance 0: defaults with fixed cycle count.
   pp_row_accumulator #(.WIDTH(92), .ROWS_PER_CYC(4), .EARLY_EXIT(1'b0)) dut_fix (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a_s), .b(b_s),
      .abort(abt[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .product(p0), .busy(bsy[0]));

   // Instance 1: defaults with early exit.
   pp_row_accumulator #(.WIDTH(92), .ROWS_PER_CYC(4), .EARLY_EXIT(1'b1)) dut_ee (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a_s), .b(b_s),
      .abort(abt[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .product(p1), .busy(bsy[1]));

   // Instance 2: 8-bit operands, 3 rows per cycle (rows do not divide width).
   pp_row_accumulator #(.WIDTH(8), .ROWS_PER_CYC(3), .EARLY_EXIT(1'b0)) dut_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a_s[7:0]), .b(b_s[7:0]),
      .abort(abt[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .product(p2), .busy(bsy[2]));

   function automatic logic [PW-1:0] prod_of(input int s);
      case (s)
         0:       return p0;
         1:       return p1;
         default: return PW'(p2);
      endcase
   endfunction

   function automatic logic [PW-1:0] model_prod(input int s, input logic [W-1:0] x, input logic [W-1:0] y);
      if (s == 2) return PW'(x[7:0]) * PW'(y[7:0]);
      return PW'(x) * PW'(y);
   endfunction

   // Cycles from accept to out_valid: N fixed, or enough row groups to cover b's top set bit.
   function automatic int model_lat(input int s, input logic [W-1:0] y);
      int wd, r, n, len, c;
      wd = (s == 2) ? 8 : 92;
      r  = (s == 2) ? 3 : 4;
      n  = ceil_div(wd, r);
      if (s != 1) return n;
      len = 0;
      for (int i = 0; i < wd; i++) if (y[i]) len = i + 1;
      c = ceil_div(len, r);
      if (c < 1) c = 1;
      if (c > n) c = n;
      return c;
   endfunction

   function automatic logic [W-1:0] rnd92();
      return W'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs == exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int s, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
      a_s = x;
      b_s = y;
      iv[s[1:0]] = 1'b1;
      chk1({tag, " in_ready"}, irdy[s[1:0]], 1'b1);
      tick();
      iv[s[1:0]] = 1'b0;
      a_s = rnd92();
      b_s = rnd92();
      chk1({tag, " busy"}, bsy[s[1:0]], 1'b1);
   endtask

   task automatic wait_done(input int s, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!ov[s[1:0]] && lat < 100);
   endtask

   task automatic finish_op(input int s, input string tag);
      ordy[s[1:0]] = 1'b1;
      tick();
      ordy[s[1:0]] = 1'b0;
      chk1({tag, " out_valid_clr"}, ov[s[1:0]], 1'b0);
      chk1({tag, " in_ready_back"}, irdy[s[1:0]], 1'b1);
   endtask

   task automatic run_op(input int s, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
      int lat;
      start(s, x, y, tag);
      wait_done(s, lat);
      chki({tag, " latency"}, lat, model_lat(s, y));
      chk({tag, " product"}, prod_of(s), model_prod(s, x, y));
      $display("op %s sel=%0d a=%0h b=%0h product=%0h latency=%0d", tag, s, x, y, prod_of(s), lat);
      finish_op(s, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]  x, y;
      logic [PW-1:0] e, last;
      int            lat;
      logic          seen;

      iv = '0; ordy = '0; abt = '0; a_s = '0; b_s = '0;
      repeat (2) tick();
      for (int s = 0; s < 3; s++) begin
         chk1("reset in_ready", irdy[s[1:0]], 1'b1);
         chk1("reset out_valid", ov[s[1:0]], 1'b0);
         chk1("reset busy", bsy[s[1:0]], 1'b0);
         chk("reset product", prod_of(s), '0);
      end
      rst_n = 1'b1;
      tick();

      run_op(2, W'(8'hFF), W'(8'hFF), "w8_ff");
      chk("w8_ff const", PW'(p2), PW'(16'hFE01));

      run_op(0, '1, '1, "fix_ones");
      e = '1;
      e = e - (PW'(1) << 93) + PW'(2);
      chk("fix_ones const", p0, e);

      run_op(1, W'(64'h0123456789ABCDEF), W'(5), "ee_b5");
      chk("ee_b5 const", p1, PW'(64'h05B05B05B05B05AB));
      run_op(1, rnd92(), '0, "ee_b0");

      for (int i = 0; i < 12; i++) begin
         x = rnd92();
         y = rnd92() >> $urandom_range(0, 91);
         run_op(i % 3, x, y, "rand");
      end

      // Backpressure: product stable, new operands ignored, in_ready only after the handshake.
      x = rnd92();
      y = rnd92() | (W'(1) << 91);
      last = model_prod(1, x, y);
      start(1, x, y, "bp");
      wait_done(1, lat);
      chki("bp latency", lat, model_lat(1, y));
      for (int c = 0; c < 5; c++) begin
         a_s = rnd92();
         iv[1] = 1'b1;
         chk("bp product", p1, last);
         chk1("bp in_ready", irdy[1], 1'b0);
         chk1("bp busy", bsy[1], 1'b1);
         chk1("bp out_valid", ov[1], 1'b1);
         tick();
      end
      ordy[1] = 1'b1;
      chk1("bp in_ready_pre", irdy[1], 1'b0);
      tick();
      ordy[1] = 1'b0;
      iv[1] = 1'b0;
      chk1("bp in_ready_after", irdy[1], 1'b1);
      chk1("bp out_valid_after", ov[1], 1'b0);
      chk("bp product_held", p1, last);
      $display("op bp product=%0h", p1);

      // Abort during RUN cycle 5.
      start(1, rnd92(), rnd92() | (W'(1) << 91), "abort_run");
      repeat (4) tick();
      abt[1] = 1'b1;
      tick();
      abt[1] = 1'b0;
      chk1("abort in_ready", irdy[1], 1'b1);
      chk1("abort busy", bsy[1], 1'b0);
      seen = 1'b0;
      repeat (30) begin
         tick();
         if (ov[1]) seen = 1'b1;
      end
      chk1("abort no_out_valid", seen, 1'b0);
      chk("abort product_held", p1, last);
      run_op(1, W'(3), W'(7), "after_abort");
      chk("after_abort const", p1, PW'(21));

      // Abort coinciding with an input handshake discards the operands.
      a_s = rnd92();
      b_s = rnd92();
      iv[1] = 1'b1;
      abt[1] = 1'b1;
      tick();
      iv[1] = 1'b0;
      abt[1] = 1'b0;
      chk1("abort_in in_ready", irdy[1], 1'b1);
      chk1("abort_in busy", bsy[1], 1'b0);
      $display("op abort_in in_ready=%b busy=%b", irdy[1], bsy[1]);

      // Abort coinciding with an output handshake.
      x = rnd92() | W'(1);
      y = rnd92() | W'(1);
      start(1, x, y, "abort_out");
      wait_done(1, lat);
      chki("abort_out latency", lat, model_lat(1, y));
      ordy[1] = 1'b1;
      abt[1] = 1'b1;
      tick();
      ordy[1] = 1'b0;
      abt[1] = 1'b0;
      chk1("abort_out out_valid", ov[1], 1'b0);
      chk1("abort_out in_ready", irdy[1], 1'b1);
      chk("abort_out product", p1, model_prod(1, x, y));
      $display("op abort_out product=%0h", p1);

      // Asynchronous reset mid-RUN, between clock edges.
      start(1, rnd92(), rnd92() | (W'(1) << 91), "arst");
      repeat (2) tick();
      #3 rst_n = 1'b0;
      #1;
      chk1("arst in_ready", irdy[1], 1'b1);
      chk1("arst out_valid", ov[1], 1'b0);
      chk1("arst busy", bsy[1], 1'b0);
      chk("arst product", p1, '0);
      $display("op arst in_ready=%b out_valid=%b busy=%b product=%0h", irdy[1], ov[1], bsy[1], p1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      run_op(1, W'(1) << 91, W'(2), "post_reset");
      chk("post_reset const", p1, PW'(1) << 92);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
